muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port start  input  1  request strobe; accepted only when busy=0 and flush=0.
REQ-004 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port a  input  32  first operand (rs1); sampled at accept.
REQ-006 SHALL have port b  input  32  second operand (rs2); sampled at accept.
REQ-007 SHALL have port flush  input  1  pipeline kill; aborts any operation in flight.
REQ-008 SHALL have port busy  output  1  high from accept through the done cycle inclusive.
REQ-009 SHALL have port done  output  1  single-cycle pulse; result valid in that cycle.
REQ-010 SHALL have port result  output  32  selected product half, quotient or remainder.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE: IDLE->CALC on accept; CALC->DONE after the final iteration; DONE->IDLE unconditionally next edge.
REQ-012 SHALL latch op, a and b at the accepting edge; later input changes SHALL NOT affect the operation.
REQ-013 SHALL ignore start while busy=1; no queueing, no error flag.
REQ-014 SHALL operate iteratively, one bit per cycle, 32 iterations, on operand magnitudes, with the sign fixed up in the DONE transition.
REQ-015 SHALL, for accept at edge E0, assert done for exactly the one cycle following edge E0+33, for every op including special cases.
REQ-016 SHALL form a 64-bit product; MUL returns bits [31:0], MULH/MULHSU/MULHU return bits [63:32] with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-017 SHALL round DIV/DIVU quotients toward zero; the REM/REMU remainder SHALL take the sign of a.
REQ-018 SHALL return, for divide by zero (b=0), quotient 32'hFFFF_FFFF and remainder a, for both signed and unsigned ops.
REQ-019 SHALL return, for signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF), DIV 32'h8000_0000 and REM 0.
REQ-020 SHALL hold result stable after done until the next accepted start; result SHALL be don't-care while in CALC.
REQ-021 SHALL, on flush=1 in CALC or DONE, go to IDLE at the next edge with no done pulse and with busy=0 in the following cycle.
REQ-022 SHALL NOT accept start when start=1 and flush=1 in the same IDLE cycle; flush in IDLE SHALL otherwise have no effect.

Reset
REQ-023 SHALL, with rst_n=0, immediately force state IDLE, busy=0, done=0, result=32'h0 and clear the iteration counter, independent of clk.
REQ-024 SHALL abandon an in-flight operation on reset without producing a done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-025 SHALL, when macro MULDIV_FAST_MUL_EN is defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle 33x33 signed multiplier, with done at the cycle following edge E0+1 and division unchanged.
REQ-026 SHALL, when MULDIV_FAST_MUL_EN is undefined, use the iterative multiply of REQ-014/015 with no multiplier inferred; results SHALL be bit-identical in both builds.

Verification
REQ-027 SHALL cover MUL a=7, b=-3 (32'hFFFF_FFFD) -> done 33 cycles after accept, result 32'hFFFF_FFEB; MULH with the same operands -> 32'hFFFF_FFFF.
REQ-028 SHALL cover DIV a=-7, b=2 -> 32'hFFFF_FFFD; REM a=-7, b=2 -> 32'hFFFF_FFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-029 SHALL cover DIVU a=5, b=0 -> 32'hFFFF_FFFF; REMU -> 5; DIV 32'h8000_0000 by -1 -> 32'h8000_0000, REM -> 0.
REQ-030 SHALL cover start pulsed at cycle 10 of a running op -> ignored; the first op completes with its own result and a single done.
REQ-031 SHALL cover flush at iteration 15 -> no done, busy=0 next cycle; a new start is then accepted and completes correctly.
REQ-032 SHALL cover rst_n low mid-CALC -> outputs zero asynchronously; MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF after release -> 32'hFFFF_FFFE; repeat under MULDIV_FAST_MUL_EN with a 1-cycle done check.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide, iterating one bit per cycle on operand magnitudes.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path; division stays iterative.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    state_t      state_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic [5:0]  cnt_r;
    logic [2:0]  op_r;
    logic [63:0] acc_r;
    logic [31:0] dvs_r;
    logic        neg_a_r;
    logic        neg_b_r;
    logic        b_zero_r;

    logic        accept_s;
    logic        sa_s;
    logic        sb_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_rs_s;
    logic [32:0] div_diff_s;
    logic [63:0] acc_next_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] fix_result_s;
    logic        fast_s;
    logic        last_s;

`ifdef MULDIV_FAST_MUL_EN
    logic [31:0] a_raw_r;
    logic [31:0] b_raw_r;
    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] fast_prod_s;

    // 33x33 signed product, operands sign-extended to 64 bits
    always_comb begin
        a_ext_s     = {{32{neg_a_r}}, a_raw_r};
        b_ext_s     = {{32{neg_b_r}}, b_raw_r};
        fast_prod_s = $signed(a_ext_s) * $signed(b_ext_s);
        fast_s      = ~op_r[2];
        prod_fix_s  = fast_s ? fast_prod_s : neg64(acc_r, neg_a_r ^ neg_b_r);
    end
`else
    // Iterative product only; sign applied to the magnitude result
    always_comb begin
        fast_s     = 1'b0;
        prod_fix_s = neg64(acc_r, neg_a_r ^ neg_b_r);
    end
`endif

    // Accept qualification and operand magnitudes
    always_comb begin
        accept_s = (state_r == IDLE) && start && !flush;
        sa_s     = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        sb_s     = op[2] ? ~op[0] : ~op[1];
        neg_a_s  = sa_s & a[31];
        neg_b_s  = sb_s & b[31];
        mag_a_s  = neg32(a, neg_a_s);
        mag_b_s  = neg32(b, neg_b_s);
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, dvs_r} : 33'd0);
        div_rs_s   = {acc_r[63:32], acc_r[31]};
        div_diff_s = div_rs_s - {1'b0, dvs_r};
        if (!op_r[2]) begin
            acc_next_s = {mul_sum_s, acc_r[31:1]};
        end else if (!div_diff_s[32]) begin
            acc_next_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            acc_next_s = {div_rs_s[31:0], acc_r[30:0], 1'b0};
        end
    end

    // Sign fix-up and result selection; divide by zero forces an all-ones quotient
    always_comb begin
        last_s = fast_s || (cnt_r == 6'd32);
        quo_s  = b_zero_r ? 32'hFFFF_FFFF : neg32(acc_r[31:0], neg_a_r ^ neg_b_r);
        rem_s  = neg32(acc_r[63:32], neg_a_r);
        case (op_r)
            3'b000:                 fix_result_s = prod_fix_s[31:0];
            3'b001, 3'b010, 3'b011: fix_result_s = prod_fix_s[63:32];
            3'b100, 3'b101:         fix_result_s = quo_s;
            3'b110, 3'b111:         fix_result_s = rem_s;
            default:                fix_result_s = 32'd0;
        endcase
    end

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
            cnt_r    <= 6'd0;
            op_r     <= 3'd0;
            acc_r    <= 64'd0;
            dvs_r    <= 32'd0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            b_zero_r <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            a_raw_r  <= 32'd0;
            b_raw_r  <= 32'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r  <= CALC;
                        busy_r   <= 1'b1;
                        cnt_r    <= 6'd0;
                        op_r     <= op;
                        acc_r    <= {32'd0, mag_a_s};
                        dvs_r    <= mag_b_s;
                        neg_a_r  <= neg_a_s;
                        neg_b_r  <= neg_b_s;
                        b_zero_r <= (b == 32'd0);
`ifdef MULDIV_FAST_MUL_EN
                        a_raw_r  <= a;
                        b_raw_r  <= b;
`endif
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (last_s) begin
                        state_r  <= DONE;
                        done_r   <= 1'b1;
                        result_r <= fix_result_s;
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, scoreboard on done, and
// hand sequences for ignored start, flush and mid-operation reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [20];
    logic [31:0] sb_q [$];
    int          checks = 0;
    int          failures = 0;
    int          done_count = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic int exp_latency(input logic [2:0] o);
        return o[2] ? 33 : MUL_LAT;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_count++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done with result %h expected no done", result);
            end else begin
                check("result", result, sb_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e);
        int n = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(7, 0));
        a     = $urandom;
        b     = $urandom;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, exp_latency(o));
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[3]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{3'b101, 32'd100,        32'd7,         32'd14};
        vecs[5]  = '{3'b111, 32'd100,        32'd7,         32'd2};
        vecs[6]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[7]  = '{3'b111, 32'd5,          32'd0,         32'd5};
        vecs[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[10] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[11] = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[12] = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[13] = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[14] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
        vecs[15] = '{3'b000, 32'h1234_5678,  32'd16,        32'h2345_6780};
        vecs[16] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[17] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1};
        vecs[18] = '{3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[19] = '{3'b011, 32'h8000_0000,  32'd4,         32'd2};

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Start pulsed during a running divide must be ignored
        @(negedge clk);
        start = 1'b1;
        op    = 3'b101;
        a     = 32'd1000;
        b     = 32'd10;
        sb_q.push_back(32'd100);
        d0 = done_count;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("ignored_start_done_count", done_count - d0, 32'd1);
        check("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Flush during iteration 15, then flush together with start in IDLE
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        a     = 32'd1000;
        b     = 32'd3;
        sb_q.push_back(32'd333);
        d0 = done_count;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 3'b101;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("start_with_flush_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_done", done_count - d0, 32'd0);
        run_op(3'b100, 32'd1000, 32'd3, 32'd333);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1;
        op    = 3'b101;
        a     = 32'd50;
        b     = 32'd5;
        sb_q.push_back(32'd10);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_done", {31'd0, done}, 32'd0);
        check("async_reset_result", result, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        n = 0;
        repeat (5) @(posedge clk);
        check("queue_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
